// File: rtl/except_sched_if.sv
// Request/flush/redirect bundle from the exception scheduler towards cp0 and the pipeline.
interface except_sched_if;
   logic        except_valid;
   logic        except_eret;
   logic        except_delayslot;
   logic [4:0]  except_code;
   logic [31:0] except_pc;
   logic [31:0] except_extra;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;

   modport master (
      output except_valid, except_eret, except_delayslot, except_code,
             except_pc, except_extra, flush, redirect_valid, redirect_pc, busy
   );

   modport slave (
      input  except_valid, except_eret, except_delayslot, except_code,
             except_pc, except_extra, flush, redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/except_sched.sv
// Picks the highest-priority interrupt/exception/ERET at MEM, drives the cp0 request and sequences flush + redirect.
// Optional macro EXCEPT_IRQ_SYNC_EN inserts a 2-flop synchroniser on hw_int_i.
module except_sched #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [5:0]    hw_int_i,
   input  logic          timer_int_i,
   input  logic [31:0]   status_i,
   input  logic [1:0]    cause_ip_sw_i,
   input  logic          cause_iv_i,
   input  logic [31:0]   ebase_i,
   input  logic [31:0]   epc_i,
   input  logic [31:0]   error_epc_i,
   input  logic          mem_valid_i,
   input  logic [31:0]   mem_pc_i,
   input  logic          mem_delayslot_i,
   input  logic [31:0]   mem_vaddr_i,
   input  logic [1:0]    mem_ce_i,
   input  logic [13:0]   ex_flags_i,
   input  logic          mem_tlb_mod_i,
   input  logic          mem_eret_i,
   except_sched_if.master req_o
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;
   // The take cycle is the first flush cycle, so the FLUSH state only covers the rest.
   localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rv_q, rv_d;
   logic [31:0] rpc_q, rpc_d;
   logic [5:0]  hw_sync;

`ifdef EXCEPT_IRQ_SYNC_EN
   logic [5:0] sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 6'b0;
         sync2_q <= 6'b0;
      end else begin
         sync1_q <= hw_int_i;
         sync2_q <= sync1_q;
      end
   end

   assign hw_sync = sync2_q;
`else
   assign hw_sync = hw_int_i;
`endif

   logic [7:0]  ip;
   logic        irq, can_take, int_hit;
   logic        exc_hit, is_int, is_refill;
   logic [4:0]  exc_code;
   logic [31:0] exc_extra;
   logic        take_exc, take_eret, take;
   logic [31:0] vec_base, exc_vec, tgt;
   logic [11:0] vec_off;
   logic        is_store;

   assign ip       = {hw_sync[5] | timer_int_i, hw_sync[4:0], cause_ip_sw_i};
   assign irq      = (|(ip & status_i[15:8])) & status_i[0] & ~status_i[1] & ~status_i[2];
   assign can_take = (state_q == ST_IDLE) & ~rst;
   assign int_hit  = irq & mem_valid_i;
   assign is_store = ex_flags_i[13];

   always_comb begin
      exc_hit   = mem_valid_i;
      is_int    = 1'b0;
      is_refill = 1'b0;
      exc_code  = 5'd0;
      exc_extra = 32'd0;
      if (int_hit) begin
         is_int    = 1'b1;
         exc_extra = {24'b0, ip};
      end else if (ex_flags_i[0]) begin
         exc_code  = 5'd4;
         exc_extra = mem_pc_i;
      end else if (ex_flags_i[1] | ex_flags_i[2]) begin
         exc_code  = 5'd2;
         exc_extra = mem_pc_i;
         is_refill = ex_flags_i[1];
      end else if (ex_flags_i[3]) begin
         exc_code  = 5'd11;
         exc_extra = {30'b0, mem_ce_i};
      end else if (ex_flags_i[4]) exc_code = 5'd10;
      else if (ex_flags_i[5]) exc_code = 5'd12;
      else if (ex_flags_i[6]) exc_code = 5'd13;
      else if (ex_flags_i[7]) exc_code = 5'd8;
      else if (ex_flags_i[8]) exc_code = 5'd9;
      else if (ex_flags_i[9]) begin
         exc_code  = 5'd4;
         exc_extra = mem_vaddr_i;
      end else if (ex_flags_i[10]) begin
         exc_code  = 5'd5;
         exc_extra = mem_vaddr_i;
      end else if (ex_flags_i[11] | ex_flags_i[12]) begin
         exc_code  = is_store ? 5'd3 : 5'd2;
         exc_extra = mem_vaddr_i;
         is_refill = ex_flags_i[11];
      end else if (mem_tlb_mod_i) begin
         exc_code  = 5'd1;
         exc_extra = mem_vaddr_i;
      end else begin
         exc_hit = 1'b0;
      end
   end

   assign take_exc  = can_take & exc_hit;
   assign take_eret = can_take & mem_valid_i & mem_eret_i & ~exc_hit;
   assign take      = take_exc | take_eret;

   assign vec_base = status_i[22] ? 32'hBFC0_0200 : {ebase_i[31:12], 12'h000};
   assign vec_off  = (is_refill & ~status_i[1]) ? 12'h000 :
                     (is_int & cause_iv_i)      ? 12'h200 : 12'h180;
   assign exc_vec  = vec_base + {20'b0, vec_off};
   assign tgt      = take_eret ? (status_i[2] ? error_epc_i : epc_i) : exc_vec;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (take && (FLUSH_CYCLES > 1)) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_INIT;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == 4'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      rv_d  = take;
      rpc_d = take ? tgt : rpc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rv_q    <= 1'b0;
         rpc_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rv_q    <= rv_d;
         rpc_q   <= rpc_d;
      end
   end

   assign req_o.except_valid     = take;
   assign req_o.except_eret      = take_eret;
   assign req_o.except_delayslot = take & mem_delayslot_i;
   assign req_o.except_code      = take_exc ? exc_code : 5'd0;
   assign req_o.except_pc        = take ? mem_pc_i : 32'd0;
   assign req_o.except_extra     = take_exc ? exc_extra : 32'd0;
   assign req_o.flush            = take | (state_q == ST_FLUSH);
   assign req_o.redirect_valid   = rv_q;
   assign req_o.redirect_pc      = rpc_q;
   assign req_o.busy             = (state_q != ST_IDLE);

   logic unused_bits;
   assign unused_bits = ^{status_i[31:23], status_i[21:16], status_i[7:3], ebase_i[11:0]};

endmodule

// File: tb/tb_except_sched.sv
// Bench for except_sched: per-cycle expected outputs are queued when stimulus is driven and checked at negedge.
module tb_except_sched;

   typedef struct packed {
      logic        rst;
      logic [5:0]  hw;
      logic        tm;
      logic [31:0] st;
      logic [1:0]  sw;
      logic        iv;
      logic        mv;
      logic [31:0] pc;
      logic        ds;
      logic [31:0] va;
      logic [1:0]  ce;
      logic [13:0] fl;
      logic        md;
      logic        er;
   } in_t;

   typedef struct packed {
      logic        v;
      logic        er;
      logic        ds;
      logic [4:0]  code;
      logic [31:0] pc;
      logic [31:0] ex;
      logic        fl;
      logic        rv;
      logic [31:0] rpc;
      logic        busy;
   } exp_t;

   typedef struct packed {
      in_t         i;
      logic        tk;
      logic        ee;
      logic [4:0]  code;
      logic [31:0] ex;
      logic [31:0] rpc;
   } vec_t;

`ifdef EXCEPT_IRQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int NV = 17;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  hw_int = '0;
   logic        timer_int = 1'b0;
   logic [31:0] status = '0;
   logic [1:0]  cause_ip_sw = '0;
   logic        cause_iv = 1'b0;
   logic [31:0] ebase = 32'h8000_0ABC;
   logic [31:0] epc = 32'h8000_2000;
   logic [31:0] error_epc = 32'hBFC0_0000;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_pc = '0;
   logic        mem_delayslot = 1'b0;
   logic [31:0] mem_vaddr = '0;
   logic [1:0]  mem_ce = '0;
   logic [13:0] ex_flags = '0;
   logic        mem_tlb_mod = 1'b0;
   logic        mem_eret = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t q[$];
   exp_t mon_e;
   vec_t vt[NV];

   except_sched_if req_if ();

   except_sched #(.FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .hw_int_i(hw_int), .timer_int_i(timer_int),
      .status_i(status), .cause_ip_sw_i(cause_ip_sw), .cause_iv_i(cause_iv),
      .ebase_i(ebase), .epc_i(epc), .error_epc_i(error_epc),
      .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_delayslot_i(mem_delayslot),
      .mem_vaddr_i(mem_vaddr), .mem_ce_i(mem_ce), .ex_flags_i(ex_flags),
      .mem_tlb_mod_i(mem_tlb_mod), .mem_eret_i(mem_eret), .req_o(req_if)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("except_valid", 32'(req_if.except_valid), 32'(mon_e.v));
         chk("except_eret", 32'(req_if.except_eret), 32'(mon_e.er));
         chk("flush", 32'(req_if.flush), 32'(mon_e.fl));
         chk("busy", 32'(req_if.busy), 32'(mon_e.busy));
         chk("redirect_valid", 32'(req_if.redirect_valid), 32'(mon_e.rv));
         if (mon_e.v) begin
            chk("except_pc", req_if.except_pc, mon_e.pc);
            chk("except_delayslot", 32'(req_if.except_delayslot), 32'(mon_e.ds));
         end
         if (mon_e.v && !mon_e.er) begin
            chk("except_code", 32'(req_if.except_code), 32'(mon_e.code));
            chk("except_extra", req_if.except_extra, mon_e.ex);
         end
         if (mon_e.rv) chk("redirect_pc", req_if.redirect_pc, mon_e.rpc);
      end
   end

   function automatic in_t mki(input logic [31:0] st, input logic [13:0] fl,
                               input logic [31:0] pc, input logic [31:0] va);
      in_t i;
      i = '0;
      i.mv = 1'b1;
      i.st = st;
      i.fl = fl;
      i.pc = pc;
      i.va = va;
      return i;
   endfunction

   function automatic vec_t mkv(input in_t i, input logic tk, input logic ee,
                                input logic [4:0] code, input logic [31:0] ex, input logic [31:0] rpc);
      vec_t v;
      v.i = i; v.tk = tk; v.ee = ee; v.code = code; v.ex = ex; v.rpc = rpc;
      return v;
   endfunction

   function automatic exp_t e_zero();
      exp_t e;
      e = '0;
      return e;
   endfunction

   function automatic exp_t e_take(input logic ee, input logic ds, input logic [4:0] code,
                                   input logic [31:0] pc, input logic [31:0] ex);
      exp_t e;
      e = '0;
      e.v = 1'b1; e.er = ee; e.ds = ds; e.code = code; e.pc = pc; e.ex = ex; e.fl = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_redir(input logic [31:0] rpc);
      exp_t e;
      e = '0;
      e.fl = 1'b1; e.rv = 1'b1; e.rpc = rpc; e.busy = 1'b1;
      return e;
   endfunction

   task automatic step(input in_t i, input exp_t e);
      @(posedge clk);
      #1;
      rst = i.rst; hw_int = i.hw; timer_int = i.tm; status = i.st; cause_ip_sw = i.sw;
      cause_iv = i.iv; mem_valid = i.mv; mem_pc = i.pc; mem_delayslot = i.ds;
      mem_vaddr = i.va; mem_ce = i.ce; ex_flags = i.fl; mem_tlb_mod = i.md; mem_eret = i.er;
      q.push_back(e);
   endtask

   in_t i, idle, sysin, h;

   initial begin
      idle = '0;
      i = mki(32'h0, 14'h0080, 32'h8000_1000, 32'h0);
      vt[0] = mkv(i, 1, 0, 5'd8, 32'h0, 32'h8000_0180);
      i = mki(32'h0, 14'h0420, 32'h8000_1004, 32'h3);
      vt[1] = mkv(i, 1, 0, 5'd12, 32'h0, 32'h8000_0180);
      i = mki(32'h0, 14'h2800, 32'h8000_1008, 32'h0040_1234);
      vt[2] = mkv(i, 1, 0, 5'd3, 32'h0040_1234, 32'h8000_0000);
      i = mki(32'h2, 14'h2800, 32'h8000_1008, 32'h0040_1234);
      vt[3] = mkv(i, 1, 0, 5'd3, 32'h0040_1234, 32'h8000_0180);
      i = mki(32'h4, 14'h0, 32'h8000_100C, 32'h0); i.er = 1'b1;
      vt[4] = mkv(i, 1, 1, 5'd0, 32'h0, 32'hBFC0_0000);
      i = mki(32'h4, 14'h0001, 32'h8000_3001, 32'h0); i.er = 1'b1;
      vt[5] = mkv(i, 1, 0, 5'd4, 32'h8000_3001, 32'h8000_0180);
      i = mki(32'h0, 14'h0, 32'h8000_100C, 32'h0); i.er = 1'b1;
      vt[6] = mkv(i, 1, 1, 5'd0, 32'h0, 32'h8000_2000);
      i = mki(32'h0040_0000, 14'h0002, 32'h8000_5000, 32'h0);
      vt[7] = mkv(i, 1, 0, 5'd2, 32'h8000_5000, 32'hBFC0_0200);
      i = mki(32'h0, 14'h0008, 32'h8000_4004, 32'h0); i.ds = 1'b1; i.ce = 2'd2;
      vt[8] = mkv(i, 1, 0, 5'd11, 32'h2, 32'h8000_0180);
      i = mki(32'h0, 14'h0, 32'h8000_1010, 32'h1000); i.md = 1'b1;
      vt[9] = mkv(i, 1, 0, 5'd1, 32'h1000, 32'h8000_0180);
      i = mki(32'h0, 14'h0080, 32'h8000_1000, 32'h0); i.mv = 1'b0;
      vt[10] = mkv(i, 0, 0, 5'd0, 32'h0, 32'h0);
      i = mki(32'h101, 14'h0080, 32'h8000_1014, 32'h0); i.sw = 2'b01; i.iv = 1'b1;
      vt[11] = mkv(i, 1, 0, 5'd0, 32'h1, 32'h8000_0200);
      i = mki(32'h100, 14'h0, 32'h8000_1014, 32'h0); i.sw = 2'b01;
      vt[12] = mkv(i, 0, 0, 5'd0, 32'h0, 32'h0);
      i = mki(32'h8001, 14'h0, 32'h8000_1018, 32'h0); i.tm = 1'b1;
      vt[13] = mkv(i, 1, 0, 5'd0, 32'h80, 32'h8000_0180);
      i = mki(32'h0, 14'h1000, 32'h8000_101C, 32'h7000);
      vt[14] = mkv(i, 1, 0, 5'd2, 32'h7000, 32'h8000_0180);
      i = mki(32'h103, 14'h0, 32'h8000_1020, 32'h0); i.sw = 2'b01;
      vt[15] = mkv(i, 0, 0, 5'd0, 32'h0, 32'h0);
      i = mki(32'h0040_0101, 14'h0, 32'h8000_1024, 32'h0); i.sw = 2'b01;
      vt[16] = mkv(i, 1, 0, 5'd0, 32'h1, 32'hBFC0_0380);

      // Reset holds every output low even with a live syscall presented.
      sysin = mki(32'h0, 14'h0080, 32'h8000_1000, 32'h0);
      i = sysin; i.rst = 1'b1;
      step(i, e_zero());
      step(i, e_zero());
      step(idle, e_zero());

      for (int k = 0; k < NV; k++) begin
         if (vt[k].tk) begin
            step(vt[k].i, e_take(vt[k].ee, vt[k].i.ds, vt[k].code, vt[k].i.pc, vt[k].ex));
            step(idle, e_redir(vt[k].rpc));
            step(idle, e_zero());
         end else begin
            step(vt[k].i, e_zero());
         end
      end

      // Event during FLUSH is ignored; a new one is accepted at T+FLUSH_CYCLES.
      step(sysin, e_take(0, 0, 5'd8, 32'h8000_1000, 32'h0));
      step(sysin, e_redir(32'h8000_0180));
      i = mki(32'h0, 14'h0010, 32'h8000_1100, 32'h0);
      step(i, e_take(0, 0, 5'd10, 32'h8000_1100, 32'h0));
      step(idle, e_redir(32'h8000_0180));
      step(idle, e_zero());

      // Reset in the flush cycle aborts and suppresses the redirect.
      step(sysin, e_take(0, 0, 5'd8, 32'h8000_1000, 32'h0));
      i = idle; i.rst = 1'b1;
      step(i, e_zero());
      step(idle, e_zero());
      step(idle, e_zero());

      // hw_int[2] -> IP4 with IM=0x10; then the same with IE=0.
      h = mki(32'h1001, 14'h0, 32'h8000_6000, 32'h0); h.hw = 6'b000100;
      for (int k = 0; k < SYNC_LAT; k++) step(h, e_zero());
      step(h, e_take(0, 0, 5'd0, 32'h8000_6000, 32'h10));
      step(idle, e_redir(32'h8000_0180));
      step(idle, e_zero());
      step(idle, e_zero());
      h.st = 32'h1000;
      for (int k = 0; k < SYNC_LAT + 2; k++) step(h, e_zero());
      step(idle, e_zero());

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
